// File: rtl/sn_bus_pkg.sv
// Shared field positions, byte markers, FSM states and latch-byte encoder
// for the SN76489 parallel bus writer.
package sn_bus_pkg;

  localparam int CH_MSB   = 2;
  localparam int CH_LSB   = 1;
  localparam int TYPE_BIT = 0;
  localparam int NUM_TONE = 3;

  localparam logic       LATCH_MARK = 1'b1;
  localparam logic [1:0] DATA_MARK  = 2'b00;
  localparam logic [1:0] NOISE_CH   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  // The noise control register only has 3 meaningful bits; bit 3 must go out as 0.
  function automatic logic [7:0] encode_latch(input logic [1:0] ch, input logic t,
                                              input logic [3:0] v_lo);
    logic [3:0] lo;
    lo = v_lo;
    if (ch == NOISE_CH && !t) lo[3] = 1'b0;
    return {LATCH_MARK, ch, t, lo};
  endfunction

endpackage

// File: rtl/sn_ready_sync.sv
// Two-flop synchronizer bringing the PSG READY line into the clk domain.
module sn_ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/sn_bus_writer.sv
// SN76489 bus initiator: encodes (adress, value) commands into latch/data bytes
// and strobes them out on WEb paced by READY. Optional tone dedup: SNW_DEDUP_EN.
module sn_bus_writer
  import sn_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int WE_MIN_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd_adress,
  input  logic [9:0] cmd_value,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] pd_out,
  output logic       web_out,
  input  logic       ready_in,
  output logic       busy,
  output logic       err_timeout
);

  localparam int MAX_A   = (SETUP_CYC > WE_MIN_CYC) ? SETUP_CYC : WE_MIN_CYC;
  localparam int MAX_B   = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LAST    = CNT_W'(WE_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pd_q, pd_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic             more_q, more_d;
  logic             err_q, err_d;

  logic       ready_s;
  logic       accept;
  logic       dup;
  logic [1:0] ch_in;
  logic       t_in;
  logic       tone_in;
  logic       strobe_ok;
  logic       strobe_to;
  logic       to_evt;

  sn_ready_sync u_ready_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ready_in),
    .sync_out (ready_s)
  );

  assign ch_in   = cmd_adress[CH_MSB:CH_LSB];
  assign t_in    = cmd_adress[TYPE_BIT];
  assign tone_in = !t_in && (ch_in != NOISE_CH);
  assign accept  = cmd_valid && cmd_ready;

  // Counter holds cycles already spent in the current state, so "elapsed" is cnt_q + 1.
  assign strobe_ok = (cnt_q >= WE_LAST) && ready_s;
  assign strobe_to = (cnt_q >= TO_LAST) && !ready_s;
  assign to_evt    = (state_q == ST_STROBE) && strobe_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pd_q        <= '0;
      data_byte_q <= '0;
      more_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pd_q        <= pd_d;
      data_byte_q <= data_byte_d;
      more_q      <= more_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  if (cnt_q == SETUP_LAST) state_d = ST_STROBE;
      ST_STROBE: if (strobe_ok || strobe_to) state_d = ST_HOLD;
      ST_HOLD:   if (cnt_q == HOLD_LAST) state_d = more_q ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    pd_d        = pd_q;
    data_byte_d = data_byte_q;
    more_d      = more_q;
    err_d       = 1'b0;
    if (accept) begin
      pd_d        = encode_latch(ch_in, t_in, cmd_value[3:0]);
      data_byte_d = {DATA_MARK, cmd_value[9:4]};
      more_d      = tone_in && !dup;
    end
    if (to_evt) begin
      more_d = 1'b0;
      err_d  = 1'b1;
    end
    // The data byte only reaches the bus once the latch byte's hold window is over.
    if (state_q == ST_HOLD && state_d == ST_SETUP) begin
      pd_d   = data_byte_q;
      more_d = 1'b0;
    end
  end

  always_comb begin
    web_out     = (state_q != ST_STROBE);
    busy        = (state_q != ST_IDLE);
    cmd_ready   = (state_q == ST_IDLE) && !rst;
    pd_out      = pd_q;
    err_timeout = err_q;
  end

`ifdef SNW_DEDUP_EN
  logic [1:0]          ch_q, ch_d;
  logic                tone_q, tone_d;
  logic                done_evt;
  logic [NUM_TONE-1:0] hit;

  // Last byte of the command left the bus cleanly.
  assign done_evt = (state_q == ST_STROBE) && strobe_ok && !more_q;

  always_comb begin
    ch_d   = ch_q;
    tone_d = tone_q;
    if (accept) begin
      ch_d   = ch_in;
      tone_d = tone_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= '0;
      tone_q <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      tone_q <= tone_d;
    end
  end

  for (genvar gi = 0; gi < NUM_TONE; gi++) begin : g_shadow
    logic       vld_q, vld_d;
    logic [5:0] val_q, val_d;
    logic       own;

    assign own     = tone_q && (ch_q == 2'(gi));
    assign hit[gi] = vld_q && (val_q == cmd_value[9:4]) && (ch_in == 2'(gi));

    always_comb begin
      vld_d = vld_q;
      val_d = val_q;
      if (own && to_evt) begin
        vld_d = 1'b0;
      end else if (own && done_evt) begin
        vld_d = 1'b1;
        val_d = data_byte_q[5:0];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        val_q <= '0;
      end else begin
        vld_q <= vld_d;
        val_q <= val_d;
      end
    end
  end

  assign dup = tone_in && (|hit);
`else
  assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_sn_bus_writer.sv
// Scoreboard bench for sn_bus_writer: each strobe is captured as (byte, low cycles, gap cycles).
module tb_sn_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd_adress = '0;
  logic [9:0] cmd_value = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] pd_out;
  logic       web_out;
  logic       ready_in = 1'b1;
  logic       busy;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  b;
    logic [15:0] len;
    logic [15:0] gap;
  } strobe_t;

  strobe_t exp_q[$];
  strobe_t obs_q[$];

  sn_bus_writer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_adress  (cmd_adress),
    .cmd_value   (cmd_value),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .pd_out      (pd_out),
    .web_out     (web_out),
    .ready_in    (ready_in),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Monitor: low = strobe length, gap = busy cycles with WEb high before the strobe.
  bit         web_prev = 1'b1;
  int         low_cnt = 0;
  int         gap_cnt = 0;
  int         gap_at = 0;
  int         err_cnt = 0;
  logic [7:0] byte_at = '0;

  always @(negedge clk) begin
    if (err_timeout === 1'b1) err_cnt++;
    if (web_out === 1'b0) begin
      if (web_prev) begin
        byte_at = pd_out;
        gap_at  = gap_cnt;
      end
      low_cnt++;
      gap_cnt = 0;
    end else begin
      if (!web_prev) obs_q.push_back({byte_at, 16'(low_cnt), 16'(gap_at)});
      low_cnt = 0;
      gap_cnt = (busy === 1'b1) ? gap_cnt + 1 : 0;
    end
    web_prev = (web_out !== 1'b0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%b after %0d cycles want 0", name, busy, n);
    end
  endtask

  task automatic send_cmd(input logic [2:0] a, input logic [9:0] v);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cmd_adress = a;
    cmd_value  = v;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pd_out !== 8'h00) begin errors++; $display("FAIL rst_pd got %h want 00", pd_out); end
    checks++;
    if (web_out !== 1'b1) begin errors++; $display("FAIL rst_web got %b want 1", web_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_timeout); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", cmd_ready); end
    $display("reset: done");
  endtask

  task automatic test_tone();
    strobe_t e, o;
    int n = 0;
    exp_q.push_back({8'h8E, 16'd4, 16'd2});
    exp_q.push_back({8'h3F, 16'd4, 16'd4});
    send_cmd(3'd0, 10'h3FE);
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != 16) begin errors++; $display("FAIL tone_busy_len got %0d want 16", n); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL tone_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL tone_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("tone: adr=0 val=3FE busy_len=%0d", n);
  endtask

  task automatic test_atten();
    strobe_t e, o;
    int n = 0;
    exp_q.push_back({8'hD7, 16'd4, 16'd2});
    send_cmd(3'd5, 10'h007);
    do begin @(negedge clk); n++; end while (cmd_ready !== 1'b1 && n < 50);
    checks++;
    if (n != 9) begin errors++; $display("FAIL atten_ready_gap got %0d want 9", n); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL atten_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL atten_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("atten: adr=5 val=007 ready_gap=%0d", n);
  endtask

  task automatic test_noise();
    strobe_t e, o;
    exp_q.push_back({8'hE5, 16'd4, 16'd2});
    send_cmd(3'd6, 10'h00D);
    wait_idle("noise", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL noise_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL noise_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("noise: adr=6 val=00D");
  endtask

  task automatic test_ready_wait();
    strobe_t e, o;
    int n = 0;
    int err0;
    ready_in = 1'b0;
    repeat (3) @(negedge clk);
    err0 = err_cnt;
    exp_q.push_back({8'hBA, 16'd22, 16'd2});
    send_cmd(3'd3, 10'h00A);
    @(negedge clk);
    while (web_out !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (19) @(negedge clk);
    ready_in = 1'b1;
    wait_idle("ready_wait", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL ready_wait_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL ready_wait_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (err_cnt != err0) begin errors++; $display("FAIL ready_wait_err got %0d pulses want 0", err_cnt - err0); end
    $display("ready_wait: adr=3 val=00A ready low 20 strobe cycles");
  endtask

  task automatic test_timeout();
    strobe_t e, o;
    int err0;
    ready_in = 1'b0;
    repeat (3) @(negedge clk);
    err0 = err_cnt;
    exp_q.push_back({8'hA5, 16'd1024, 16'd2});
    send_cmd(3'd2, 10'h155);
    wait_idle("timeout", 1200);
    ready_in = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (err_cnt - err0 != 1) begin errors++; $display("FAIL timeout_err got %0d pulses want 1", err_cnt - err0); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle cmd_ready=%b want 1", cmd_ready); end
    $display("timeout: adr=2 val=155 err_pulses=%0d", err_cnt - err0);
  endtask

  task automatic test_rst_mid();
    strobe_t e, o;
    int n = 0;
    repeat (3) @(negedge clk);
    send_cmd(3'd0, 10'h3FE);
    @(negedge clk);
    while (web_out !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (web_out !== 1'b1) begin errors++; $display("FAIL rst_mid_web got %b want 1", web_out); end
    checks++;
    if (pd_out !== 8'h00) begin errors++; $display("FAIL rst_mid_pd got %h want 00", pd_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    rst = 1'b0;
    cmd_adress = 3'd5;
    cmd_value  = 10'h007;
    cmd_valid  = 1'b1;
    #1;
    obs_q.delete();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", cmd_ready); end
    exp_q.push_back({8'hD7, 16'd4, 16'd2});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_accept busy=%b want 1", busy); end
    wait_idle("rst_mid", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("rst_mid: aborted tone, then adr=5 val=007");
  endtask

  task automatic test_back_to_back();
    strobe_t e, o;
    int n = 0;
    exp_q.push_back({8'hD7, 16'd4, 16'd2});
    exp_q.push_back({8'hFF, 16'd4, 16'd2});
    @(negedge clk);
    cmd_adress = 3'd5;
    cmd_value  = 10'h007;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_adress = 3'd7;
    cmd_value  = 10'h00F;
    do begin @(negedge clk); n++; end while (cmd_ready !== 1'b1 && n < 50);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (n != 9) begin errors++; $display("FAIL b2b_hold_off got %0d want 9", n); end
    wait_idle("b2b", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("back_to_back: adr=5 then adr=7 hold_off=%0d", n);
  endtask

  task automatic test_dedup();
    strobe_t e, o;
    exp_q.push_back({8'hA5, 16'd4, 16'd2});
    exp_q.push_back({8'h15, 16'd4, 16'd4});
    exp_q.push_back({8'hA5, 16'd4, 16'd2});
`ifndef SNW_DEDUP_EN
    exp_q.push_back({8'h15, 16'd4, 16'd4});
`endif
    send_cmd(3'd2, 10'h155);
    wait_idle("dedup1", 100);
    send_cmd(3'd2, 10'h155);
    wait_idle("dedup2", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL dedup_strobe got b=%h len=%0d gap=%0d want b=%h len=%0d gap=%0d", o.b, o.len, o.gap, e.b, e.len, e.gap); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL dedup_extra got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    $display("dedup: two writes adr=2 val=155");
  endtask

  initial begin
    test_reset();
    test_tone();
    test_atten();
    test_noise();
    test_ready_wait();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    test_dedup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sn_bus_writer.md
Name: sn_bus_writer

Overview:
- Bus initiator for the SN76489-compatible parallel write port (pD[7:0], WEb, READY) of our PSG core.
- Accepts register-write commands in the core's internal form: 3-bit address, 10-bit value.
- Encodes each command into SN76489 latch and data bytes, then strobes them out with WEb, paced by READY.
- Sits in the host/test-stimulus FPGA that feeds the PSG core; pairs with the core's reception decoder.

Parameters:
- SETUP_CYC, 2: cycles pd_out is stable with web_out high before the strobe.
- WE_MIN_CYC, 4: minimum cycles web_out is held low.
- HOLD_CYC, 2: cycles pd_out is held after web_out rises.
- TIMEOUT_CYC, 1024: maximum cycles spent waiting for READY while web_out is low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_adress  in  3  [2:1] channel 0-3, [0] type (0 = freq/noise ctrl, 1 = attenuation)
- cmd_value  in  10  register value
- cmd_valid  in  1  command offered
- cmd_ready  out  1  writer can accept a command
- pd_out  out  8  bus data toward pD0..pD7
- web_out  out  1  write strobe, active low
- ready_in  in  1  READY from the PSG, asynchronous, high = idle
- busy  out  1  command in progress
- err_timeout  out  1  one-cycle pulse when READY wait times out

Behaviour:
- One clock: clk. Reset is synchronous, active-high, on rst.
- Reset values: cmd_ready=0 during rst and 1 the cycle after; pd_out=8'h00; web_out=1; busy=0; err_timeout=0; FSM=IDLE.
- ready_in passes through a 2-flop synchronizer; only ready_s is used.
- Accept: cmd_valid && cmd_ready, legal only in IDLE. Command is latched; cmd_ready drops the next cycle.
- Encoding (ch = cmd_adress[2:1], t = cmd_adress[0]):
  - Latch byte = {1, ch, t, v[3:0]}.
  - ch=3, t=0 (noise ctrl): v[3] forced 0.
  - Data byte = {0, 0, v[9:4]}. Sent only when t=0 and ch<3.
  - All other commands send one byte.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP for the next byte | IDLE).
  - SETUP: pd_out = current byte, web_out=1, for SETUP_CYC cycles. pd_out is valid the cycle after accept.
  - STROBE: web_out=0. Exit when at least WE_MIN_CYC cycles have elapsed and ready_s=1.
  - STROBE timeout: if the cycle count reaches TIMEOUT_CYC with ready_s=0, pulse err_timeout, drop any remaining byte, go to HOLD.
  - HOLD: web_out=1, pd_out unchanged, for HOLD_CYC cycles.
- busy=1 from the cycle after accept until the return to IDLE. cmd_ready = (state==IDLE) && !rst.
- Counters are sized clog2 of the largest parameter + 1; no wrap is reachable.
- rst mid-command: the next cycle web_out=1, pd_out=0, FSM=IDLE, the command is discarded, shadow state is invalidated.
- cmd_valid while busy: ignored (held off by cmd_ready=0).
- ready_s already 1 at strobe entry: the strobe still lasts exactly WE_MIN_CYC cycles.

Optional Feature:
- Macro SNW_DEDUP_EN.
- Defined:
  - Keep a shadow of v[9:4] plus a valid bit for each of tone channels 0-2, updated on every completed (non-timed-out) tone write.
  - A tone write whose v[9:4] equals a valid shadow entry sends the latch byte only.
  - Shadow entries are invalidated by rst or by a timeout on that channel.
- Undefined: tone writes always send both bytes; no shadow registers.

Decomposition:
- Package sn_bus_pkg:
  - Channel and type field positions.
  - Latch/data byte marker bits.
  - FSM state enum.
  - Function encoding a latch byte from (ch, t, v).
- Sub-module sn_ready_sync: 2-flop synchronizer for ready_in.

Test Plan:
- Tone, adress=0, value=10'h3FE, READY tied 1 -> bytes 8'h8E then 8'h3F. Each byte: web_out low exactly 4 cycles, 2 setup, 2 hold. busy high throughout.
- Attenuation, adress=5, value=7 -> single byte 8'hD7. cmd_ready back to 1 after 9 cycles.
- Noise, adress=6, value=10'h00D -> single byte 8'hE5 (v[3] masked).
- READY held low 20 cycles after the strobe starts -> web_out stays low until 2 cycles after READY rises (synchronizer delay). No err_timeout.
- READY stuck low -> err_timeout pulses once after 1024 strobe cycles. The data byte of a tone command is not sent; writer returns to IDLE.
- rst asserted mid-STROBE -> web_out=1 and pd_out=0 the next cycle; a new command is accepted the cycle after rst deasserts.
- SNW_DEDUP_EN defined: two writes of adress=2, value=10'h155 -> first sends 8'hA5, 8'h15; second sends 8'hA5 only.
